dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning address width.
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0 (CPU) or requester 1 (debug/DMA).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  AW  access address.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 SHALL have ports lock0/lock1  input  1  hold ownership after the current access.
REQ-010 SHALL have ports gnt0/gnt1  output  1  access accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1  output  1  read data valid.
REQ-012 SHALL have ports rdata0/rdata1  output  DW  read data.
REQ-013 SHALL have ports mem_wen, mem_waddr[AW], mem_wdata[DW], mem_raddr[AW]  output  drive the synchronous single-port-pair data memory.
REQ-014 SHALL have port mem_rdata  input  DW  memory read data, valid one edge after mem_raddr is presented.

Function
REQ-015 SHALL implement states IDLE, OWN0 and OWN1 with a 1-bit round-robin pointer rr (the requester with priority on the next tie).
REQ-016 In IDLE, SHALL grant the single requester when exactly one req is high; SHALL grant requester rr when both are high.
REQ-017 In OWNn, SHALL grant only requester n; the other requester's req SHALL be ignored, with its gnt held low.
REQ-018 gnt SHALL be combinational from req, state and rr; at most one gnt SHALL be high in any cycle.
REQ-019 A granted write SHALL drive mem_wen=1, mem_waddr=addr, and mem_wdata=wdata in the same cycle; the write commits on that edge.
REQ-020 A granted read SHALL drive mem_raddr=addr in the same cycle.
REQ-021 A granted read SHALL assert rvalidn with rdatan=mem_rdata exactly one cycle later; rvalid SHALL be low otherwise.
REQ-022 rdata0/rdata1 SHALL be 0 when the matching rvalid is low.
REQ-023 mem_wen SHALL be 0 in every cycle with no granted write.
REQ-024 mem_raddr/mem_waddr SHALL hold their last value when idle.
REQ-025 Transitions on the edge after granting requester n:
- lockn=1 -> OWNn.
- lockn=0 -> IDLE, rr <= ~n.
REQ-026 In OWNn with lockn=0 and reqn=0, SHALL return to IDLE with rr <= ~n.
REQ-027 In OWNn, SHALL remain in OWNn while lockn=1, even with reqn=0.
REQ-028 In OWNn, SHALL NOT exceed 16 consecutive grants; after the 16th grant it SHALL force IDLE with rr <= ~n regardless of lockn.
- A 5-bit burst counter SHALL clear on entry to IDLE.
REQ-029 Back-to-back accesses SHALL be accepted every cycle; a read followed by a write to the same address SHALL return the old data.
REQ-030 A requester SHALL keep req, we, addr and wdata stable until gnt; the arbiter does not register request fields.

Reset
REQ-031 While rst_n=0, SHALL reset asynchronously to: state=IDLE, rr=0, burst counter=0, rvalid0/1=0, rdata0/1=0, mem_wen=0, mem_waddr=0, mem_wdata=0, mem_raddr=0.
REQ-032 gnt0 and gnt1 SHALL be 0 while rst_n=0.
REQ-033 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-034 Operation SHALL resume on the first rising edge with rst_n=1.

Verification
REQ-035 Reset, then req0 write addr 0x10 data 0xA5 -> gnt0=1, mem_wen=1, waddr 0x10; next cycle req0 read 0x10 -> rvalid0=1, rdata0=0xA5 one cycle later.
REQ-036 Both req high every cycle, no lock -> grants alternate 0,1,0,1…; first grant goes to requester 0 (rr=0 after reset).
REQ-037 req1 with lock1=1 for 3 accesses while req0 is held high -> gnt0=0 throughout; gnt0=1 on the first cycle after lock1 drops.
REQ-038 lock0 held with continuous req0 and req1 high -> exactly 16 gnt0 pulses, then gnt1=1 on the next cycle.
REQ-039 Granted read at 0x20 then granted write 0x20=0x3C on the next cycle -> rdata returns the old value; a later read returns 0x3C.
REQ-040 rst_n pulled low mid-burst (OWN1, pending read) -> all outputs 0 immediately, no rvalid after release; the next request is served from IDLE with rr=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter with lock and round-robin
//
// Purpose: arbitrates a CPU (requester 0) and a debug/DMA port (requester 1)
// onto a synchronous data memory with separate read and write address ports.
// A requester can take ownership with lockn. Ownership ends after at most 16
// consecutive grants. Ties in IDLE go to the round-robin pointer rr.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN       request fields, held stable until gntN
//   lockN                          keep ownership after the current access
//   gntN                           access accepted this cycle (combinational)
//   rvalidN, rdataN                read data, one cycle after a granted read
//   mem_wen/waddr/wdata/raddr      memory control for the same cycle
//   mem_rdata                      memory read data, one edge after mem_raddr
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // The 16th grant of an ownership is taken when the counter still reads 15
    localparam logic [4:0] BURST_LAST = 5'd15;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [4:0]    burst_q, burst_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] raddr_q;
    logic [DW-1:0] wdata_q;

    logic          granted;
    logic          gsel;
    logic          g_we;
    logic          g_lock;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          own_lock;

    // Grant decode. Gating with rst_n keeps both grants low during reset.
    // This also keeps the memory strobes at their reset values while reset is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || !rr_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign granted = gnt0 | gnt1;
    assign gsel    = gnt1;
    assign g_we    = gsel ? we1    : we0;
    assign g_lock  = gsel ? lock1  : lock0;
    assign g_addr  = gsel ? addr1  : addr0;
    assign g_wdata = gsel ? wdata1 : wdata0;

    // Memory addresses and data track the granted access.
    // They hold the last value otherwise.
    assign mem_wen   = granted & g_we;
    assign mem_waddr = mem_wen ? g_addr  : waddr_q;
    assign mem_wdata = mem_wen ? g_wdata : wdata_q;
    assign mem_raddr = (granted && !g_we) ? g_addr : raddr_q;

    assign rv0_d   = gnt0 & ~we0;
    assign rv1_d   = gnt1 & ~we1;
    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata0  = rv0_q ? mem_rdata : '0;
    assign rdata1  = rv1_q ? mem_rdata : '0;

    assign own_lock = (state_q == OWN1) ? lock1 : lock0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        if (granted) begin
            burst_d = burst_q + 5'd1;
            if (g_lock && (burst_q != BURST_LAST)) begin
                state_d = gsel ? OWN1 : OWN0;
            end else begin
                state_d = IDLE;
                rr_d    = ~gsel;
            end
        end else if (state_q != IDLE) begin
            // The owner may pause (reqn=0) without losing ownership while locked
            if (!own_lock) begin
                state_d = IDLE;
                rr_d    = (state_q == OWN0);
            end
        end
        if (state_d == IDLE) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            burst_q <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            waddr_q <= mem_waddr;
            raddr_q <= mem_raddr;
            wdata_q <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data registered from the read address
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        clr_in();
        rst_n = 0;
        req0 = 1;
        #7;
        // Reset state, with a request already pending
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        @(negedge clk);
        clr_in();
        rst_n = 1;

        // Write 0x10=0xA5, then read it back
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        #1;
        chk("wr_gnt0", gnt0, 1);
        chk("wr_gnt1", gnt1, 0);
        chk("wr_wen", mem_wen, 1);
        chk("wr_waddr", mem_waddr, 8'h10);
        chk("wr_wdata", mem_wdata, 8'hA5);
        @(negedge clk);
        we0 = 0;
        #1;
        chk("rd_gnt0", gnt0, 1);
        chk("rd_wen", mem_wen, 0);
        chk("rd_raddr", mem_raddr, 8'h10);
        chk("rd_rvalid_early", rvalid0, 0);
        @(negedge clk);
        clr_in();
        #1;
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 8'hA5);
        chk("idle_waddr_hold", mem_waddr, 8'h10);
        chk("idle_wen", mem_wen, 0);
        @(negedge clk);
        #1;
        chk("rd_rvalid0_drop", rvalid0, 0);
        chk("rd_rdata0_zero", rdata0, 0);

        // Round-robin alternation from reset
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
            #1;
            chk($sformatf("rr_gnt0_%0d", k), gnt0, (k % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", k), gnt1, (k % 2 == 1));
            if (k > 0) chk($sformatf("rr_rvalid0_%0d", k), rvalid0, (k % 2 == 1));
        end
        @(negedge clk);
        clr_in();

        // Lock by requester 1 shuts out requester 0
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h11; lock1 = 1;
        #1;
        chk("lk_a_gnt1", gnt1, 1);
        @(negedge clk);
        req0 = 1; addr0 = 8'h30;
        #1;
        chk("lk_b_gnt1", gnt1, 1);
        chk("lk_b_gnt0", gnt0, 0);
        @(negedge clk);
        lock1 = 0;
        #1;
        chk("lk_c_gnt1", gnt1, 1);
        chk("lk_c_gnt0", gnt0, 0);
        @(negedge clk);
        #1;
        chk("lk_d_gnt0", gnt0, 1);
        chk("lk_d_gnt1", gnt1, 0);
        @(negedge clk);
        clr_in();
        #1;
        chk("lk_e_rvalid0", rvalid0, 1);
        chk("lk_e_rdata0", rdata0, 8'h11);

        // Burst limit: 16 grants while locked, then the other requester
        do_reset();
        req0 = 1; req1 = 1; lock0 = 1; addr0 = 8'h05; addr1 = 8'h06;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("bl_gnt0_%0d", k), gnt0, 1);
            chk($sformatf("bl_gnt1_%0d", k), gnt1, 0);
        end
        @(negedge clk);
        #1;
        chk("bl_after_gnt0", gnt0, 0);
        chk("bl_after_gnt1", gnt1, 1);
        @(negedge clk);
        clr_in();

        // Read then write same address returns old data
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h77;
        #1;
        chk("rw_pre_wen", mem_wen, 1);
        @(negedge clk);
        we0 = 0;
        #1;
        chk("rw_rd_gnt0", gnt0, 1);
        chk("rw_rd_raddr", mem_raddr, 8'h20);
        @(negedge clk);
        we0 = 1; wdata0 = 8'h3C;
        #1;
        chk("rw_wr_gnt0", gnt0, 1);
        chk("rw_wr_wen", mem_wen, 1);
        chk("rw_old_rvalid", rvalid0, 1);
        chk("rw_old_rdata", rdata0, 8'h77);
        @(negedge clk);
        we0 = 0;
        #1;
        chk("rw_rd2_rvalid", rvalid0, 0);
        chk("rw_rd2_raddr", mem_raddr, 8'h20);
        @(negedge clk);
        clr_in();
        #1;
        chk("rw_new_rvalid", rvalid0, 1);
        chk("rw_new_rdata", rdata0, 8'h3C);
        chk("idle_raddr_hold", mem_raddr, 8'h20);

        // Reset mid-burst in OWN1 with a read granted
        @(negedge clk);
        req1 = 1; lock1 = 1; addr1 = 8'h20;
        #1;
        chk("mr_gnt1_a", gnt1, 1);
        @(negedge clk);
        #1;
        chk("mr_gnt1_b", gnt1, 1);
        chk("mr_rvalid1_b", rvalid1, 1);
        #1;
        rst_n = 0;
        #1;
        chk("mr_rst_gnt1", gnt1, 0);
        chk("mr_rst_rvalid1", rvalid1, 0);
        chk("mr_rst_rdata1", rdata1, 0);
        chk("mr_rst_raddr", mem_raddr, 0);
        chk("mr_rst_waddr", mem_waddr, 0);
        chk("mr_rst_wdata", mem_wdata, 0);
        chk("mr_rst_wen", mem_wen, 0);
        @(negedge clk);
        clr_in();
        rst_n = 1;
        #1;
        chk("mr_post_rvalid1", rvalid1, 0);
        @(negedge clk);
        req0 = 1; req1 = 1;
        #1;
        chk("mr_next_gnt0", gnt0, 1);
        chk("mr_next_gnt1", gnt1, 0);
        @(negedge clk);
        clr_in();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
